// File: rtl/alu_pkg.sv
// Shared op_code values, scoreboard state encoding and the ALU reference model
// used by alu_result_scoreboard.
package alu_pkg;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAILED = 2'd2
    } sb_state_t;

    localparam int unsigned REF_W = 64;

    // Operands are zero-extended into REF_W bits; n is the live datapath width.
    // Returns {c, v, z, out} with out masked to n bits.
    function automatic logic [REF_W+2:0] alu_ref(input logic [2:0] op,
                                                  input logic [REF_W-1:0] a,
                                                  input logic [REF_W-1:0] b,
                                                  input int unsigned n);
        logic [REF_W-1:0] mask;
        logic [REF_W-1:0] nb;
        logic [REF_W-1:0] out;
        logic [REF_W:0]   sum;
        logic             sa, sb, so, c, v, z;
        mask = REF_W'(((REF_W+1)'(1) << n) - (REF_W+1)'(1));
        sa   = |(({1'b0, a} >> (n - 1)) & (REF_W+1)'(1));
        sb   = |(({1'b0, b} >> (n - 1)) & (REF_W+1)'(1));
        nb   = ~b & mask;
        sum  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_MOV:  sum = {1'b0, a};
            OP_NOT:  sum = {1'b0, ~a};
            OP_ADD:  sum = {1'b0, a} + {1'b0, b};
            OP_NOR:  sum = {1'b0, ~(a | b)};
            OP_SUB:  sum = {1'b0, a} + {1'b0, nb} + (REF_W+1)'(1);
            OP_NAND: sum = {1'b0, ~(a & b)};
            OP_AND:  sum = {1'b0, a & b};
            OP_SLT:  sum = (REF_W+1)'((sa != sb) ? sa : (a < b));
            default: sum = '0;
        endcase
        out = REF_W'(sum) & mask;
        so  = |(({1'b0, out} >> (n - 1)) & (REF_W+1)'(1));
        if (op == OP_ADD || op == OP_SUB)
            c = |((sum >> n) & (REF_W+1)'(1));
        if (op == OP_ADD)
            v = (sa == sb) && (so != sa);
        if (op == OP_SUB)
            v = (sa != sb) && (so != sa);
        z = (out == '0);
        return {c, v, z, out};
    endfunction

endpackage

// File: rtl/alu_sb_fifo.sv
// Parameterised FIFO for queued ALU operations; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module alu_sb_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wptr[AW-1:0]] <= din;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/alu_result_scoreboard.sv
// Result-side scoreboard for the ALU: queues issued ops, predicts results with
// alu_ref, compares returned results and keeps pass/fail counts and a first-failure capture.
import alu_pkg::*;

module alu_result_scoreboard #(
    parameter int unsigned N            = 32,
    parameter int unsigned DEPTH        = 4,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         iss_valid,
    output logic         iss_ready,
    input  logic [2:0]   iss_op,
    input  logic [N-1:0] iss_a,
    input  logic [N-1:0] iss_b,
    input  logic         res_valid,
    input  logic [N-1:0] res_out,
    input  logic         res_c_out,
    input  logic         res_zero,
    input  logic         res_overflow,
    output logic [15:0]  pass_count,
    output logic [15:0]  fail_count,
    output logic         orphan,
    output logic         ff_valid,
    output logic [2:0]   ff_op,
    output logic [N-1:0] ff_a,
    output logic [N-1:0] ff_b,
    output logic [N-1:0] ff_got,
    output logic [N-1:0] ff_exp,
    output logic [5:0]   ff_flags,
    output logic [1:0]   state
);
    localparam int unsigned EW = 3 + 2 * N;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    sb_state_t         st;
    logic              flush, failed, push, pop, full, empty;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic [2:0]        head_op;
    logic [N-1:0]      head_a, head_b;
    logic [REF_W+2:0]  ref_res;
    logic [N-1:0]      exp_out;
    logic [2:0]        exp_f;

    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [N-1:0]      s1_a, s1_b, s1_got, s1_exp;
    logic [2:0]        s1_got_f, s1_exp_f;
    logic              commit, mismatch;

    assign flush     = rst || clear;
    assign failed    = (st == ST_FAILED);
    assign iss_ready = !full && !failed;
    assign push      = iss_valid && iss_ready;
    assign pop       = res_valid && !empty && !failed;
    assign state     = st;

    alu_sb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({iss_op, iss_a, iss_b}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign {head_op, head_a, head_b} = head;

    // Flags are kept in {c, z, v} order to match the ff_flags layout.
    always_comb begin
        ref_res = alu_ref(head_op, REF_W'(head_a), REF_W'(head_b), N);
        exp_out = N'(ref_res);
        exp_f   = {ref_res[REF_W+2], ref_res[REF_W], ref_res[REF_W+1]};
    end

    always_ff @(posedge clk) begin
        if (flush)
            s1_valid <= 1'b0;
        else
            s1_valid <= pop;
        if (pop) begin
            s1_op    <= head_op;
            s1_a     <= head_a;
            s1_b     <= head_b;
            s1_got   <= res_out;
            s1_got_f <= {res_c_out, res_zero, res_overflow};
            s1_exp   <= exp_out;
            s1_exp_f <= exp_f;
        end
    end

    assign commit   = s1_valid && !failed;
    assign mismatch = ({s1_got, s1_got_f} != {s1_exp, s1_exp_f});

    always_ff @(posedge clk) begin
        if (flush) begin
            st         <= ST_EMPTY;
            pass_count <= '0;
            fail_count <= '0;
            orphan     <= 1'b0;
            ff_valid   <= 1'b0;
            ff_op      <= '0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_got     <= '0;
            ff_exp     <= '0;
            ff_flags   <= '0;
        end else begin
            if (res_valid && empty && !failed)
                orphan <= 1'b1;
            if (commit) begin
                if (mismatch) begin
                    if (fail_count != 16'hFFFF)
                        fail_count <= fail_count + 16'd1;
                    if (!ff_valid) begin
                        ff_valid <= 1'b1;
                        ff_op    <= s1_op;
                        ff_a     <= s1_a;
                        ff_b     <= s1_b;
                        ff_got   <= s1_got;
                        ff_exp   <= s1_exp;
                        ff_flags <= {s1_got_f, s1_exp_f};
                    end
                end else if (pass_count != 16'hFFFF) begin
                    pass_count <= pass_count + 16'd1;
                end
            end
            case (st)
                ST_FAILED: st <= ST_FAILED;
                default: begin
                    if (commit && mismatch && STOP_ON_FAIL)
                        st <= ST_FAILED;
                    else if (push)
                        st <= ST_RUN;
                    else if (pop && count == CW'(1))
                        st <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_result_scoreboard.md
# alu_result_scoreboard

Hardware scoreboard that sits on the result side of the `ALU` block. It queues each issued operation (op_code, R2, R3) and computes the expected result and flags from its own reference model. It then compares each returned ALU result against the oldest queued operation and maintains pass/fail counters plus a first-failure capture. The block lets the ALU be checked on-board or in a self-checking bench without a separate golden-model module.

## Interface
Parameters:
- `N`, 32, datapath width, matching the ALU `n`.
- `DEPTH`, 4, number of outstanding operations; power of two, at least 2.
- `STOP_ON_FAIL`, 0. When 1, the block halts on the first mismatch.

Ports:
- `clk`, input, 1. Single clock; all logic is rising-edge.
- `rst`, input, 1. Synchronous, active-high reset.
- `clear`, input, 1. Synchronous soft clear, with the same effect as `rst`.
- `iss_valid`, input, 1. An operation is offered.
- `iss_ready`, output, 1. The queue can accept an operation.
- `iss_op`, input, 3. ALU op_code.
- `iss_a`, input, N. R2 operand.
- `iss_b`, input, N. R3 operand.
- `res_valid`, input, 1. One ALU result is presented this cycle.
- `res_out`, input, N. ALU R0.
- `res_c_out`, input, 1. ALU carry flag.
- `res_zero`, input, 1. ALU zero flag.
- `res_overflow`, input, 1. ALU overflow flag.
- `pass_count`, output, 16. Number of matching results; saturating.
- `fail_count`, output, 16. Number of mismatching results; saturating.
- `orphan`, output, 1. Sticky flag: a result arrived while the queue was empty.
- `ff_valid`, output, 1. Sticky flag: a first failure has been captured.
- `ff_op`, output, 3. Op_code of the first failure.
- `ff_a`, output, N. R2 operand of the first failure.
- `ff_b`, output, N. R3 operand of the first failure.
- `ff_got`, output, N. Result value returned by the ALU at the first failure.
- `ff_exp`, output, N. Expected result value at the first failure.
- `ff_flags`, output, 6. Flags at the first failure: {got c,z,v, exp c,z,v}.
- `state`, output, 2. Current FSM state.

## Operation
- Reference model. a = R2, b = R3; all arithmetic is N+1 bits wide.
  - 000 MOV: out = a.
  - 001 NOT: out = ~a.
  - 010 ADD: {c,out} = a + b. v = signed overflow (a[N-1] == b[N-1] and out[N-1] differs from them).
  - 011 NOR: out = ~(a | b).
  - 100 SUB: {c,out} = a + ~b + 1. v = (a[N-1] != b[N-1]) and (out[N-1] != a[N-1]).
  - 101 NAND: out = ~(a & b).
  - 110 AND: out = a & b.
  - 111 SLT: out = 1 if signed a < b, otherwise 0. The comparison is exact even when a - b overflows.
  - c and v are 0 for every op except ADD and SUB.
  - For every op, zero = (out == 0).
- Queue: a FIFO of {op, a, b} with DEPTH entries.
  - Push when `iss_valid && iss_ready`.
  - Pop when `res_valid` is high and the queue is non-empty.
- `iss_ready` = !full, and the FSM is not in FAILED.
- Comparison is a match only when all of out, c, zero and overflow are equal.
- FSM states:
  - EMPTY (0): the queue is empty.
  - RUN (1): the queue is non-empty.
  - FAILED (2): only reachable when STOP_ON_FAIL = 1.
- FSM transitions:
  - EMPTY to RUN on a push.
  - RUN to EMPTY when the last entry is popped with no push in the same cycle.
  - Any state to FAILED when a mismatch is committed and STOP_ON_FAIL = 1.
  - FAILED is left only by `rst` or `clear`.
  - In FAILED, results are ignored and counters are frozen.
- Boundary conditions:
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - When full, no push occurs, but a pop still occurs.
  - `res_valid` on an empty queue sets `orphan` and causes no pop and no count. A same-cycle push is not bypassed.
  - Counters hold at 16'hFFFF once saturated.
  - `ff_*` are written only on the first mismatch after reset or clear.
- `rst` or `clear` mid-operation:
  - Flushes the queue and the compare stage.
  - Zeroes all outputs. `state` = EMPTY and `iss_ready` = 1 on the following cycle.
  - If `rst`/`clear` coincides with a mismatch, the mismatch is discarded.

## Timing
- Reset values are 0 on every output except `iss_ready`, which resets to 1.
- Issue-to-result spacing is unconstrained; a result can arrive as early as the cycle after its issue.
- Compare pipeline:
  - Cycle T: `res_valid` pops the head, and the expected value is computed combinationally.
  - T+1: got and expected values are registered.
  - T+2: counters, `ff_*` and FAILED become visible.
- A result can be accepted every cycle (throughput 1/cycle).
- `orphan` is visible at T+1.

## Structure
- Package `alu_pkg` holds:
  - op_code localparams OP_MOV..OP_SLT (000..111).
  - the state encoding.
  - the function `alu_ref(op, a, b)` returning {c, v, z, out}.
- Sub-module `alu_sb_fifo`: a parameterised FIFO with full/empty flags, using wrap-around pointers one bit wider than log2(DEPTH).
- The top level contains the FSM, the compare stage, the counters and the capture registers.

## Test plan
- ADD check:
  - Stimulus: issue ADD FFFFFFFF+FFFFFFFF and return out=FFFFFFFE, c=1, z=0, v=0.
  - Response: pass_count=1 at T+2.
- SUB overflow check:
  - Stimulus: issue SUB 7FFFFFFF-FFFFFFFF and return out=80000000, c=0, v=1.
  - Response: pass.
  - Stimulus: return the same result with v=0.
  - Response: fail_count=1, ff_valid=1, ff_exp=80000000.
- SLT sweep:
  - Stimulus: issue SLT 7FFFFFFF vs 80000001, expecting out=0; then FFFFFFFF vs 5, expecting out=1; return the expected values.
  - Response: 2 passes, with z=1 on the first.
- Queue full and orphan:
  - Stimulus: 4 issues with no results.
  - Response: iss_ready=0 on the fifth offer.
  - Stimulus: simultaneous push and pop while full.
  - Response: the push is refused.
  - Stimulus: drain the queue, then send an extra res_valid.
  - Response: orphan=1 and the counters are unchanged.
- STOP_ON_FAIL=1:
  - Stimulus: a mismatch on NAND AAAAAAAA, 55555555 (expected FFFFFFFF, got 0).
  - Response: state=FAILED and iss_ready=0; further results are ignored.
  - Stimulus: clear.
  - Response: state=EMPTY, with counters and ff_valid at 0.
- Reset mid-run:
  - Stimulus: assert rst while 3 operations are queued and one compare is in flight.
  - Response: counts stay 0 and the queue is empty on the next cycle.
